jpeg_info_fifo_arbiter: RTL and testbench
=========================================

Name: jpeg_info_fifo_arbiter

Overview:
- Shares one synchronous (c_FIFO_TYPE "SYN") JPEG encode info FIFO write port between N_REQ record producers, such as encoder cores and header or marker generators.
- Each producer presents multi-word info records using valid/ready/last. Grants are round-robin per record, so a record is never interleaved with another requester's words.
- No new record starts while the FIFO is almost full.
- Sits directly in front of the FIFO write port, in the same clock domain as the FIFO.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: info word width; must equal the FIFO c_WR_DATA_WIDTH.
- MAX_REC_WORDS, 16: maximum words per grant. Exceeding it force-terminates the grant.
- CNT_WIDTH, 16: width of the committed-record counter.

Ports:
- clk  in  1: single clock; also drives the FIFO wr_clk.
- rst  in  1: asynchronous, active-high reset.
- req_valid  in  N_REQ: per-requester word valid.
- req_data  in  N_REQ*DATA_WIDTH: per-requester word. Requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  N_REQ: marks the final word of a record.
- req_ready  out  N_REQ: word accepted when valid & ready.
- fifo_wr_en  out  1: to FIFO wr_en.
- fifo_wr_data  out  DATA_WIDTH: to FIFO wr_data.
- fifo_wr_full  in  1: from FIFO wr_full.
- fifo_almost_full  in  1: from FIFO almost_full.
- grant_id  out  clog2(N_REQ): current or last granted requester.
- busy  out  1: high while in XFER.
- err_long  out  1: sticky; a grant was force-terminated at MAX_REC_WORDS.
- clr_err  in  1: synchronous clear of err_long.
- rec_cnt  out  CNT_WIDTH: records committed (last word written); wraps modulo 2^CNT_WIDTH.

Behaviour:
Reset values (asynchronous):
- state = IDLE.
- rr_ptr = N_REQ-1, so requester 0 has priority first.
- grant_id = 0, word_cnt = 0, err_long = 0, rec_cnt = 0.
- busy = 0, req_ready = 0, fifo_wr_en = 0.

State machine, states IDLE and XFER:
- IDLE → XFER when |req_valid and !fifo_almost_full.
  - Winner is the first asserted req_valid searching from rr_ptr+1 upward, wrapping modulo N_REQ.
  - grant_id and rr_ptr are registered to the winner; word_cnt is set to 0.
  - No word is accepted in the IDLE cycle.
  - Turnaround cost is one cycle per record.
- In IDLE, fifo_almost_full = 1 blocks every new grant, even when requests are pending.
- In XFER the datapath is combinational:
  - g = grant_id.
  - req_ready[g] = !fifo_wr_full; all other req_ready are 0.
  - fifo_wr_en = req_valid[g] & !fifo_wr_full.
  - fifo_wr_data = req_data[g].
  - Zero-cycle latency from requester to FIFO.
  - Because the gating is combinational, the FIFO is never written while full.
- Accepted word (fifo_wr_en = 1): word_cnt increments.
- XFER → IDLE on an accepted word with req_last[g] = 1. rec_cnt increments on the same edge.
- XFER → IDLE on an accepted word without req_last when word_cnt = MAX_REC_WORDS-1. This is a force-terminate:
  - err_long is set.
  - rec_cnt does not increment.
  - The requester's remaining words are arbitrated later as a new grant.
- In XFER, fifo_almost_full is ignored; the record in progress completes into the almost-full headroom.
- fifo_wr_full = 1 in XFER stalls the transfer: ready = 0, state and counters hold.
- req_valid[g] = 0 in XFER (a bubble) holds the grant indefinitely. No timeout.
- A requester deasserting valid in IDLE before a grant loses nothing; no request is latched.
- clr_err and a force-terminate on the same edge: the set wins.
- Asynchronous reset during XFER abandons the partial record. No fifo_wr_en is asserted during reset. The FIFO is reset separately by the integrator.
- grant_id width is max(1, clog2(N_REQ)).

Decomposition:
- Shared package jpeg_info_pkg holds:
  - constants INFO_W = 32 and INFO_MAX_REC_WORDS = 16;
  - function clog2;
  - an enum for arbiter states (IDLE = 1'b0, XFER = 1'b1).
- One sub-module, jpeg_info_rr_pick: combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are winner index and found flag.
- Everything else (FSM, counters, mux) stays in the top module.

Test Plan:
- Single requester, N_REQ=4: req 1 sends 3 words A0, A1, A2 with last on A2 → grant_id=1 one cycle after valid; fifo_wr_data sequence A0, A1, A2 on consecutive cycles; rec_cnt=1; busy drops the cycle after A2.
- Contention: reqs 0, 2, 3 each hold a 2-word record from reset → grant order 0, 2, 3. Then req 0 re-requests → order continues with 0 after 3, and no words are interleaved.
- Full stall: fifo_wr_full=1 for 5 cycles mid-record → fifo_wr_en=0 and req_ready=0 during the stall; word order intact; word_cnt holds.
- Almost-full: fifo_almost_full=1 while in IDLE with req_valid=4'b0001 → stays IDLE, busy=0. almost_full asserted mid-record → record completes.
- Long record, MAX_REC_WORDS=4: 6-word record → grant ends after word 4; err_long=1; rec_cnt unchanged; words 5–6 sent in a later grant with rec_cnt+1. clr_err → err_long=0.
- Reset mid-XFER after 2 words → outputs go to reset values immediately (asynchronously); after release, requester 0 has priority.

Source files
------------

// File: rtl/jpeg_info_pkg.sv
// Shared definitions for the JPEG encode info FIFO write-port arbiter.
// Constants, the arbiter state encoding and a constant-foldable ceil(log2).
package jpeg_info_pkg;

    localparam int INFO_W             = 32;
    localparam int INFO_MAX_REC_WORDS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/jpeg_info_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from rr_ptr+1, wrapping modulo N_REQ.
module jpeg_info_rr_pick
    import jpeg_info_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    // Scan all requesters once, starting just after the last winner.
    always_comb begin
        int idx;
        winner = {IDX_W{1'b0}};
        found  = 1'b0;
        idx    = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end else begin
                found  = found;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/jpeg_info_fifo_arbiter.sv
// Round-robin, record-atomic arbiter sharing one info FIFO write port between
// N_REQ producers; the granted requester is muxed straight onto the FIFO.
module jpeg_info_fifo_arbiter
    import jpeg_info_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_WIDTH    = INFO_W,
    parameter int MAX_REC_WORDS = INFO_MAX_REC_WORDS,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [N_REQ-1:0]                                  req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]                       req_data,
    input  logic [N_REQ-1:0]                                  req_last,
    output logic [N_REQ-1:0]                                  req_ready,
    output logic                                              fifo_wr_en,
    output logic [DATA_WIDTH-1:0]                             fifo_wr_data,
    input  logic                                              fifo_wr_full,
    input  logic                                              fifo_almost_full,
    output logic [((clog2(N_REQ) > 1) ? clog2(N_REQ) : 1)-1:0] grant_id,
    output logic                                              busy,
    output logic                                              err_long,
    input  logic                                              clr_err,
    output logic [CNT_WIDTH-1:0]                              rec_cnt
);

    localparam int GW  = (clog2(N_REQ) > 1) ? clog2(N_REQ) : 1;
    localparam int WCW = clog2(MAX_REC_WORDS) + 1;
    localparam logic [WCW-1:0] LAST_IDX = WCW'(MAX_REC_WORDS - 1);

    arb_state_e      state_r;
    logic [GW-1:0]   rr_ptr_r;
    logic [WCW-1:0]  word_cnt_r;
    logic [GW-1:0]   pick_winner_s;
    logic            pick_found_s;
    logic            sel_valid_s;
    logic            sel_last_s;
    logic            accept_s;

    jpeg_info_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (GW)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_r),
        .winner (pick_winner_s),
        .found  (pick_found_s)
    );

    // Zero-latency datapath: only the granted requester sees ready, and full gates it.
    always_comb begin
        req_ready    = {N_REQ{1'b0}};
        fifo_wr_data = {DATA_WIDTH{1'b0}};
        sel_valid_s  = 1'b0;
        sel_last_s   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if ((state_r == XFER) && (grant_id == GW'(i))) begin
                req_ready[i] = ~fifo_wr_full;
                fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid_s  = req_valid[i];
                sel_last_s   = req_last[i];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    assign accept_s   = sel_valid_s & ~fifo_wr_full;
    assign fifo_wr_en = accept_s;

    // Grant FSM with word/record counters and the sticky overlength flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= GW'(N_REQ - 1);
            grant_id   <= {GW{1'b0}};
            word_cnt_r <= {WCW{1'b0}};
            err_long   <= 1'b0;
            rec_cnt    <= {CNT_WIDTH{1'b0}};
            busy       <= 1'b0;
        end else begin
            if (clr_err) begin
                err_long <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    // almost_full only blocks new records, never one in flight
                    if (pick_found_s && !fifo_almost_full) begin
                        state_r    <= XFER;
                        busy       <= 1'b1;
                        grant_id   <= pick_winner_s;
                        rr_ptr_r   <= pick_winner_s;
                        word_cnt_r <= {WCW{1'b0}};
                    end
                end
                XFER: begin
                    if (accept_s) begin
                        word_cnt_r <= word_cnt_r + WCW'(1);
                        if (sel_last_s) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            rec_cnt <= rec_cnt + CNT_WIDTH'(1);
                        end else if (word_cnt_r == LAST_IDX) begin
                            state_r  <= IDLE;
                            busy     <= 1'b0;
                            err_long <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_info_fifo_arbiter.sv
// Self-checking bench: per-requester source queues feed the DUT, an expected
// word queue is filled in predicted grant order and drained on every FIFO write.
module tb_jpeg_info_fifo_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_wr_full;
    logic            fifo_almost_full;
    logic [1:0]      grant_id;
    logic            busy;
    logic            err_long;
    logic            clr_err;
    logic [15:0]     rec_cnt;

    jpeg_info_fifo_arbiter #(
        .N_REQ         (NR),
        .DATA_WIDTH    (DW),
        .MAX_REC_WORDS (4),
        .CNT_WIDTH     (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_full     (fifo_wr_full),
        .fifo_almost_full (fifo_almost_full),
        .grant_id         (grant_id),
        .busy             (busy),
        .err_long         (err_long),
        .clr_err          (clr_err),
        .rec_cnt          (rec_cnt)
    );

    always #5 clk = ~clk;

    logic [32:0] src_q [NR][$];
    logic [31:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          wr_total = 0;
    int          rec_tag = 0;
    logic [15:0] exp_rec = 16'd0;

    logic        s_wr_en, s_busy, s_err_long;
    logic [3:0]  s_ready;
    logic [1:0]  s_grant;
    logic [15:0] s_rec_cnt;

    // Queue an n-word record for requester r; last on the final word only.
    task automatic load(input int r, input int n);
        logic [31:0] w;
        rec_tag++;
        for (int k = 0; k < n; k++) begin
            w = 32'hA000_0000 | (32'(r) << 24) | (32'(rec_tag) << 8) | 32'(k);
            src_q[r].push_back({(k == n - 1) ? 1'b1 : 1'b0, w});
            exp_q.push_back(w);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    // One cycle: drive at negedge, sample 1ns later, score, then advance.
    task automatic tick();
        logic [31:0] w;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_last[i]  = src_q[i][0][32];
                req_data[i*DW +: DW] = src_q[i][0][31:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i*DW +: DW] = 32'd0;
            end
        end
        #1;
        s_wr_en = fifo_wr_en; s_busy = busy; s_ready = req_ready;
        s_grant = grant_id; s_err_long = err_long; s_rec_cnt = rec_cnt;
        checks++;
        if (fifo_wr_en !== (|(req_valid & req_ready))) begin
            errors++;
            $display("FAIL wr_en_vs_handshake: wr_en=%b valid=%b ready=%b", fifo_wr_en, req_valid, req_ready);
        end
        if (fifo_wr_full && fifo_wr_en) begin
            errors++;
            $display("FAIL write_while_full: wr_en=1 required 0");
        end
        if (fifo_wr_en === 1'b1) begin
            wr_total++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: data=%h with empty scoreboard", fifo_wr_data);
            end else begin
                w = exp_q.pop_front();
                if (fifo_wr_data !== w) begin
                    errors++;
                    $display("FAIL word_order: got %h expected %h", fifo_wr_data, w);
                end
            end
        end
        for (int i = 0; i < NR; i++)
            if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_empty(input int max_cycles);
        int n = 0;
        while (pending() && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (pending() || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending words=%0d expected left=%0d required 0", 1, exp_q.size());
        end
    endtask

    task automatic wait_writes(input int target, input int max_cycles);
        int n = 0;
        while (wr_total < target && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (wr_total < target) begin
            errors++;
            $display("FAIL write_wait_timeout: writes=%0d required %0d", wr_total, target);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete();
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_wr_full = 1'b0; fifo_almost_full = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rec = 16'd0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({busy, req_ready, fifo_wr_en, grant_id, err_long, rec_cnt} !== 26'd0) begin
            errors++;
            $display("FAIL reset_values: busy=%b ready=%b wr_en=%b gid=%0d err=%b rec=%0d required all 0",
                     busy, req_ready, fifo_wr_en, grant_id, err_long, rec_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        load(1, 3);
        tick();
        checks++;
        if (s_wr_en !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_cycle: wr_en=%b busy=%b required 0 0", s_wr_en, s_busy);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (s_wr_en !== 1'b1 || s_busy !== 1'b1 || s_grant !== 2'd1) begin
                errors++;
                $display("FAIL single_word%0d: wr_en=%b busy=%b gid=%0d required 1 1 1", k, s_wr_en, s_busy, s_grant);
            end
        end
        exp_rec++;
        tick();
        checks++;
        if (s_busy !== 1'b0 || s_rec_cnt !== exp_rec || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_end: busy=%b rec=%0d required 0 %0d", s_busy, s_rec_cnt, exp_rec);
        end
    endtask

    task automatic test_contention();
        do_reset();
        load(0, 2); load(2, 2); load(3, 2); load(0, 2);
        run_until_empty(40);
        exp_rec += 16'd4;
        tick();
        checks++;
        if (s_rec_cnt !== exp_rec || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_count: rec=%0d busy=%b required %0d 0", s_rec_cnt, s_busy, exp_rec);
        end
    endtask

    task automatic test_full_stall();
        load(2, 4);
        wait_writes(wr_total + 1, 6);
        fifo_wr_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (s_wr_en !== 1'b0 || s_ready !== 4'b0000 || s_busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d: wr_en=%b ready=%b busy=%b required 0 0000 1", k, s_wr_en, s_ready, s_busy);
            end
        end
        fifo_wr_full = 1'b0;
        run_until_empty(10);
        exp_rec++;
        tick();
        checks++;
        if (s_rec_cnt !== exp_rec || s_err_long !== 1'b0) begin
            errors++;
            $display("FAIL stall_commit: rec=%0d err=%b required %0d 0", s_rec_cnt, s_err_long, exp_rec);
        end
    endtask

    task automatic test_almost_full();
        fifo_almost_full = 1'b1;
        load(0, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (s_busy !== 1'b0 || s_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL af_idle_block%0d: busy=%b wr_en=%b required 0 0", k, s_busy, s_wr_en);
            end
        end
        fifo_almost_full = 1'b0;
        run_until_empty(6);
        load(1, 3);
        wait_writes(wr_total + 1, 6);
        fifo_almost_full = 1'b1;
        run_until_empty(6);
        exp_rec += 16'd2;
        tick();
        checks++;
        if (s_rec_cnt !== exp_rec || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL af_midrecord: rec=%0d busy=%b required %0d 0", s_rec_cnt, s_busy, exp_rec);
        end
        fifo_almost_full = 1'b0;
    endtask

    task automatic test_long_record();
        load(3, 6);
        wait_writes(wr_total + 4, 10);
        tick();
        checks++;
        if (s_busy !== 1'b0 || s_err_long !== 1'b1 || s_rec_cnt !== exp_rec) begin
            errors++;
            $display("FAIL long_terminate: busy=%b err=%b rec=%0d required 0 1 %0d", s_busy, s_err_long, s_rec_cnt, exp_rec);
        end
        run_until_empty(8);
        exp_rec++;
        tick();
        checks++;
        if (s_rec_cnt !== exp_rec || s_err_long !== 1'b1) begin
            errors++;
            $display("FAIL long_tail: rec=%0d err=%b required %0d 1", s_rec_cnt, s_err_long, exp_rec);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        checks++;
        if (s_err_long !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: err=%b required 0", s_err_long);
        end
    endtask

    task automatic test_reset_mid_xfer();
        load(2, 3);
        wait_writes(wr_total + 2, 8);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, req_ready, fifo_wr_en, grant_id, err_long, rec_cnt} !== 26'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%b ready=%b wr_en=%b gid=%0d rec=%0d required all 0",
                     busy, req_ready, fifo_wr_en, grant_id, rec_cnt);
        end
        for (int i = 0; i < NR; i++) src_q[i].delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        exp_rec = 16'd0;
        load(0, 1);
        load(2, 1);
        run_until_empty(10);
        exp_rec += 16'd2;
        tick();
        checks++;
        if (s_rec_cnt !== exp_rec) begin
            errors++;
            $display("FAIL post_reset_priority: rec=%0d required %0d", s_rec_cnt, exp_rec);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        fifo_wr_full = 1'b0; fifo_almost_full = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_almost_full();
        test_long_record();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
